bp_clint_ctrl: RTL and testbench
================================

Name: bp_clint_ctrl

Overview:
- Core-local interruptor (CLINT) controller for the 0x0200_0000 device window.
- Owns and sequences the memory-mapped machine timer (mtime), the per-core compare registers (mtimecmp) and the per-core software-interrupt bits (msip).
- Services one memory-mapped request at a time from the uncached I/O path and drives per-core timer and software interrupt lines to the cores' CSR logic.

Parameters:
- num_core_p, 1: number of cores; one msip and one mtimecmp per core; legal range 1..16.
- paddr_width_p, 56: physical address width, matching SV39.
- timer_div_p, 8: clk_i cycles per mtime increment; must be at least 1.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  synchronous, active-high reset.
- cmd_v_i  in  1  request valid.
- cmd_ready_o  out  1  controller can accept a request.
- cmd_w_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  paddr_width_p  physical byte address.
- cmd_size_i  in  2  access size: 2 = 4B, 3 = 8B; 0 and 1 are illegal.
- cmd_data_i  in  64  write data, LSB-aligned.
- resp_v_o  out  1  response valid.
- resp_data_o  out  64  read data, LSB-aligned; 0 for writes.
- resp_err_o  out  1  unmapped, illegal-size or misaligned access.
- resp_yumi_i  in  1  response consumed.
- software_irq_o  out  num_core_p  msip[i].
- timer_irq_o  out  num_core_p  registered (mtime >= mtimecmp[i]).

Behaviour:
- Clock is clk_i; reset is synchronous, active-high, and named reset_i.
- Register map (offset from 0x0200_0000):
  - msip[i] at 0x0000 + 4*i: bit 0 only; reads return zero-extended.
  - mtimecmp[i] at 0x4000 + 8*i.
  - mtime at 0xBFF8.
- Any address outside these registers, including i >= num_core_p, is unmapped.
- Decode uses cmd_addr_i[15:0] after checking that the upper bits equal 0x0200 in [31:16] and zero above bit 31.
- FSM has two states, e_ready and e_resp:
  - e_ready: cmd_ready_o = 1. On cmd_v_i, the request is accepted in that cycle, the read data is captured and the write is committed at that clock edge. Next state is e_resp.
  - e_resp: cmd_ready_o = 0 and resp_v_o = 1. resp_data_o and resp_err_o are held stable. On resp_yumi_i, go to e_ready. The next command is accepted no earlier than the following cycle, so there is one outstanding request at most.
- Latency: response is valid 1 cycle after acceptance.
- 4B access to a 64-bit register:
  - addr[2] selects the half: 0 = low, 1 = high.
  - A write updates only that half from cmd_data_i[31:0].
  - A read returns that half in resp_data_o[31:0], upper bits zero.
- 8B access to a 64-bit register requires addr[2:0] = 0.
- 8B access to msip is illegal (error).
- Error cases: size 0/1, misalignment (addr not a multiple of the size), or unmapped address.
  - No state change.
  - resp_err_o = 1, resp_data_o = 0.
  - The response still completes the handshake.
- mtime and prescaler:
  - The prescaler counts 0..timer_div_p-1; mtime increments by 1 when it wraps.
  - mtime wraps from 2^64-1 to 0 with no flag.
  - A write to mtime (either half) in the same cycle as an increment: the written value wins, and the increment is dropped for that cycle.
  - For a 4B write, the other half keeps its pre-increment value.
  - The prescaler is not reset by mtime writes.
- timer_irq_o[i] is registered from the compare of the current mtime and mtimecmp[i]. It updates 1 cycle after either operand changes and deasserts 1 cycle after mtimecmp is written above mtime.
- software_irq_o[i] equals msip[i] and changes the cycle after the write is accepted.
- Reset values:
  - mtime = 0, prescaler = 0, mtimecmp[i] = all ones, msip = 0.
  - State = e_ready, cmd_ready_o = 1, resp_v_o = 0, resp_data_o = 0, resp_err_o = 0, all irq outputs 0.
- Reset mid-transaction (in e_resp) drops the pending response; no write is undone.

Decomposition:
- Add to the shared common package:
  - offset constants: msip offset 0x0000, mtimecmp offset 0x4000, mtime offset 0xBFF8;
  - the access-size enum: 4B = 2, 8B = 3;
  - the FSM state enum.
- Device base addresses already live there and are reused.
- One sub-module: bp_clint_mtime_counter. It holds the prescaler, the 64-bit mtime, and the write-override ports (w_v, w_mask hi/lo, w_data).

Test Plan:
- Reset, then idle 8*timer_div_p = 64 cycles (default timer_div_p = 8) -> 8B read of 0x0200_BFF8 returns 8 (±1 for the read cycle). cmd_ready_o = 1 out of reset; irqs are 0.
- Write msip[0] = 0xFFFF_FFFF (4B) -> software_irq_o[0] = 1 the next cycle. Read returns 0x1. Write 0 -> irq falls the next cycle.
- Write mtimecmp[0] = 0x20 (8B) while mtime < 0x20 -> timer_irq_o[0] rises exactly 1 cycle after mtime reaches 0x20. Write mtimecmp[0] = 0xFFFF_FFFF_FFFF_FFFF -> it falls the next cycle.
- 4B write of 0x1 to 0x0200_BFFC (mtime high half) in the same cycle as a prescaler wrap -> mtime = 0x0000_0001_xxxx_xxxx with the low half unincremented. No lost or double increment afterward.
- Error cases (read 0x0200_5000, 8B read of 0x0200_4004, size 1 write to msip) -> resp_err_o = 1, data 0, no register changes.
- Hold resp_yumi_i low for 5 cycles with cmd_v_i high -> resp_v_o, data and err are stable, cmd_ready_o = 0. Only one command is accepted after yumi. Assert reset_i in e_resp -> resp_v_o = 0 the next cycle.

Source files
------------

// File: rtl/bp_clint_ctrl_pkg.sv
// bp_clint_ctrl_pkg
//   Shared definitions for the core-local interruptor (CLINT).
//   - Device base address of the CLINT window.
//   - Register offsets inside the 64 KiB window (msip, mtimecmp, mtime).
//   - Access-size encoding of the uncached I/O command path.
//   - Controller FSM state encoding.
package bp_clint_ctrl_pkg;

  localparam logic [63:0] clint_dev_base_addr = 64'h0000_0000_0200_0000;

  localparam logic [15:0] clint_msip_offset     = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_offset = 16'h4000;
  localparam logic [15:0] clint_mtime_offset    = 16'hBFF8;

  typedef enum logic [1:0] {
    e_size_4 = 2'd2,
    e_size_8 = 2'd3
  } clint_size_e;

  typedef enum logic {
    e_ready = 1'b0,
    e_resp  = 1'b1
  } clint_state_e;

endpackage

// File: rtl/bp_clint_mtime_counter.sv
// bp_clint_mtime_counter
//   Prescaler plus the free-running 64-bit machine timer.
//   The prescaler counts 0..timer_div_p-1 and mtime steps by one each time it
//   wraps. A write (i_w_v) overrides the selected halves of mtime; in that
//   cycle any pending increment is dropped and unselected halves keep their
//   current (pre-increment) value. Writes never touch the prescaler.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_w_v               write mtime this cycle
//   i_w_mask_lo/hi      which 32-bit halves take i_w_data
//   i_w_data            write value, already placed in the target half
//   o_mtime             current mtime
module bp_clint_mtime_counter #(
  parameter int timer_div_p = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_w_v,
  input  logic        i_w_mask_lo,
  input  logic        i_w_mask_hi,
  input  logic [63:0] i_w_data,
  output logic [63:0] o_mtime
);

  localparam int pw_lp = (timer_div_p > 1) ? $clog2(timer_div_p) : 1;
  localparam logic [pw_lp-1:0] presc_max_lp = pw_lp'(timer_div_p - 1);

  logic [pw_lp-1:0] r_presc;
  logic [63:0]      r_mtime;
  logic             w_wrap;
  logic [63:0]      w_mtime_written;

  assign w_wrap = (r_presc == presc_max_lp);

  assign w_mtime_written = {i_w_mask_hi ? i_w_data[63:32] : r_mtime[63:32],
                            i_w_mask_lo ? i_w_data[31:0]  : r_mtime[31:0]};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + 1'b1;
      if (i_w_v) begin
        r_mtime <= w_mtime_written;
      end else if (w_wrap) begin
        r_mtime <= r_mtime + 64'd1;
      end
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/bp_clint_ctrl.sv
// bp_clint_ctrl
//   CLINT controller for the 0x0200_0000 window. Owns msip, mtimecmp and
//   mtime, services one memory-mapped request at a time and drives the
//   per-core software and timer interrupt lines.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   cmd_v_i/cmd_ready_o   request handshake
//   cmd_w_i               1 = write, 0 = read
//   cmd_addr_i            physical byte address
//   cmd_size_i            2 = 4B, 3 = 8B (others illegal)
//   cmd_data_i            write data, LSB-aligned
//   resp_v_o/resp_yumi_i  response handshake
//   resp_data_o           read data (0 for writes and errors)
//   resp_err_o            unmapped / illegal size / misaligned
//   software_irq_o        msip per core
//   timer_irq_o           registered mtime >= mtimecmp per core
//   dbg_state_o           controller FSM state
//
// Handshake: a request transfers on a clock edge where cmd_v_i and
// cmd_ready_o are both high; the response transfers on an edge where
// resp_v_o and resp_yumi_i are both high. While resp_v_o is high the
// response data/err are held and cmd_ready_o is low, so at most one request
// is ever outstanding.
module bp_clint_ctrl
  import bp_clint_ctrl_pkg::*;
#(
  parameter int num_core_p    = 1,
  parameter int paddr_width_p = 56,
  parameter int timer_div_p   = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  output logic                     cmd_ready_o,
  input  logic                     cmd_w_i,
  input  logic [paddr_width_p-1:0] cmd_addr_i,
  input  logic [1:0]               cmd_size_i,
  input  logic [63:0]              cmd_data_i,
  output logic                     resp_v_o,
  output logic [63:0]              resp_data_o,
  output logic                     resp_err_o,
  input  logic                     resp_yumi_i,
  output logic [num_core_p-1:0]    software_irq_o,
  output logic [num_core_p-1:0]    timer_irq_o,
  output clint_state_e             dbg_state_o
);

  clint_state_e r_state, w_state_n;

  logic [num_core_p-1:0] r_msip;
  logic [63:0]           r_mtimecmp [num_core_p];
  logic [num_core_p-1:0] r_timer_irq;
  logic [63:0]           r_resp_data;
  logic                  r_resp_err;

  logic [15:0] w_off;
  logic        w_base_hit, w_is_4, w_is_8, w_misalign;
  logic        w_msip_hit, w_cmp_hit, w_mtime_hit, w_err;
  logic [3:0]  w_msip_idx, w_cmp_idx;
  logic        w_accept, w_wr_ok;
  logic        w_msip_sel;
  logic [63:0] w_cmp_sel, w_reg64, w_rd_data, w_wdata, w_mtime;
  logic        w_mask_lo, w_mask_hi, w_mt_wv;

  // ---------------- address decode ----------------
  assign w_off      = cmd_addr_i[15:0];
  assign w_base_hit = (cmd_addr_i[31:16] == clint_dev_base_addr[31:16]) &&
                      (cmd_addr_i[paddr_width_p-1:32] == '0);
  assign w_is_4     = (cmd_size_i == e_size_4);
  assign w_is_8     = (cmd_size_i == e_size_8);
  assign w_misalign = w_is_4 ? (|w_off[1:0]) : (|w_off[2:0]);

  assign w_msip_idx  = w_off[5:2];
  assign w_cmp_idx   = w_off[6:3];
  assign w_msip_hit  = (w_off[15:6] == clint_msip_offset[15:6]) &&
                       ({1'b0, w_msip_idx} < 5'(num_core_p));
  assign w_cmp_hit   = (w_off[15:7] == clint_mtimecmp_offset[15:7]) &&
                       ({1'b0, w_cmp_idx} < 5'(num_core_p));
  assign w_mtime_hit = (w_off[15:3] == clint_mtime_offset[15:3]);

  // msip is a 32-bit register, so an 8B access to it is an error too.
  assign w_err = !(w_is_4 || w_is_8) || w_misalign || !w_base_hit ||
                 !(w_msip_hit || w_cmp_hit || w_mtime_hit) ||
                 (w_msip_hit && w_is_8);

  assign w_accept = (r_state == e_ready) && cmd_v_i;
  assign w_wr_ok  = w_accept && cmd_w_i && !w_err;

  // Per-core selects done as loops so the index width never has to match
  // the array depth.
  always_comb begin
    w_msip_sel = 1'b0;
    w_cmp_sel  = '0;
    for (int i = 0; i < num_core_p; i++) begin
      if (w_msip_idx == 4'(i)) w_msip_sel = r_msip[i];
      if (w_cmp_idx == 4'(i))  w_cmp_sel  = r_mtimecmp[i];
    end
  end

  assign w_reg64 = w_mtime_hit ? w_mtime : w_cmp_sel;

  always_comb begin
    w_rd_data = '0;
    if (!w_err && !cmd_w_i) begin
      if (w_msip_hit)  w_rd_data = {63'b0, w_msip_sel};
      else if (w_is_8) w_rd_data = w_reg64;
      else if (w_off[2]) w_rd_data = {32'b0, w_reg64[63:32]};
      else             w_rd_data = {32'b0, w_reg64[31:0]};
    end
  end

  // A 4B write's data is replicated into both halves; the masks pick one.
  assign w_wdata   = w_is_8 ? cmd_data_i : {2{cmd_data_i[31:0]}};
  assign w_mask_lo = w_is_8 || !w_off[2];
  assign w_mask_hi = w_is_8 ||  w_off[2];
  assign w_mt_wv   = w_wr_ok && w_mtime_hit;

  bp_clint_mtime_counter #(
    .timer_div_p(timer_div_p)
  ) u_mtime (
    .i_clk      (clk_i),
    .i_reset    (reset_i),
    .i_w_v      (w_mt_wv),
    .i_w_mask_lo(w_mask_lo),
    .i_w_mask_hi(w_mask_hi),
    .i_w_data   (w_wdata),
    .o_mtime    (w_mtime)
  );

  // ---------------- register file and response ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_msip      <= '0;
      r_timer_irq <= '0;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
      for (int i = 0; i < num_core_p; i++) r_mtimecmp[i] <= '1;
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        if (w_wr_ok && w_msip_hit && (w_msip_idx == 4'(i)))
          r_msip[i] <= cmd_data_i[0];
        if (w_wr_ok && w_cmp_hit && (w_cmp_idx == 4'(i))) begin
          if (w_mask_lo) r_mtimecmp[i][31:0]  <= w_wdata[31:0];
          if (w_mask_hi) r_mtimecmp[i][63:32] <= w_wdata[63:32];
        end
        r_timer_irq[i] <= (w_mtime >= r_mtimecmp[i]);
      end
      if (w_accept) begin
        r_resp_data <= w_rd_data;
        r_resp_err  <= w_err;
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= e_ready;
    else         r_state <= w_state_n;
  end

  always_comb begin
    w_state_n   = r_state;
    cmd_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    case (r_state)
      e_ready: begin
        cmd_ready_o = 1'b1;
        if (cmd_v_i) w_state_n = e_resp;
      end
      e_resp: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) w_state_n = e_ready;
      end
      default: w_state_n = e_ready;
    endcase
  end

  assign resp_data_o    = r_resp_data;
  assign resp_err_o     = r_resp_err;
  assign software_irq_o = r_msip;
  assign timer_irq_o    = r_timer_irq;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_bp_clint_ctrl.sv
module tb_bp_clint_ctrl;
  import bp_clint_ctrl_pkg::*;

  localparam int nc  = 1;
  localparam int pa  = 56;
  localparam int div = 8;
  localparam logic [pa-1:0] base = 56'h0200_0000;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          cmd_v = 1'b0, cmd_w = 1'b0, resp_yumi = 1'b0;
  logic [pa-1:0] cmd_addr = '0;
  logic [1:0]    cmd_size = 2'd0;
  logic [63:0]   cmd_data = '0;
  logic          cmd_ready_o, resp_v_o, resp_err_o;
  logic [63:0]   resp_data_o;
  logic [nc-1:0] software_irq_o, timer_irq_o;
  clint_state_e  dbg_state_o;

  always #5 clk = ~clk;

  bp_clint_ctrl #(.num_core_p(nc), .paddr_width_p(pa), .timer_div_p(div)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready_o), .cmd_w_i(cmd_w),
    .cmd_addr_i(cmd_addr), .cmd_size_i(cmd_size), .cmd_data_i(cmd_data),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .resp_yumi_i(resp_yumi), .software_irq_o(software_irq_o),
    .timer_irq_o(timer_irq_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- reference model ----------------
  // edge_cnt = number of clock edges since reset released. mtime advances on
  // every edge whose index is a multiple of div; after a write at edge kw
  // the value is the written base plus the wraps at edges kw+1..k.
  int          edge_cnt;
  logic [63:0] mt_base;
  int          kw;
  logic        msip_m;
  logic [63:0] cmp_m;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) begin
    if (reset_i) edge_cnt <= 0;
    else         edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [63:0] model_mtime(input int k);
    return mt_base + 64'(k / div - kw / div);
  endfunction

  // ---------------- driver ----------------
  // Returns the edge index of acceptance and samples taken right after it.
  task automatic do_req(input logic w, input logic [pa-1:0] a, input logic [1:0] sz,
                        input logic [63:0] d, input bit align,
                        output logic [63:0] rd, output logic er, output logic rv,
                        output logic sw, output int k);
    @(negedge clk);
    if (align)
      for (int i = 0; i < div && ((edge_cnt + 1) % div) != 0; i++) @(negedge clk);
    cmd_v = 1'b1; cmd_w = w; cmd_addr = a; cmd_size = sz; cmd_data = d;
    @(posedge clk); #1;
    k = edge_cnt;
    cmd_v = 1'b0;
    rv = resp_v_o; rd = resp_data_o; er = resp_err_o; sw = software_irq_o[0];
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset_i = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    mt_base = '0; kw = 0; msip_m = 1'b0; cmp_m = '1;
    n_checks++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready_o); end
    n_checks++; if (resp_v_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_v: got %b expected 0", resp_v_o); end
    n_checks++; if (resp_data_o !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", resp_data_o); end
    n_checks++; if (resp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", resp_err_o); end
    n_checks++; if (software_irq_o !== '0) begin n_fail++; $display("FAIL reset_sw_irq: got %b expected 0", software_irq_o); end
    n_checks++; if (timer_irq_o !== '0) begin n_fail++; $display("FAIL reset_tmr_irq: got %b expected 0", timer_irq_o); end
  endtask

  task automatic test_mtime_idle;
    logic [63:0] rd, exp; logic er, rv, sw; int k;
    repeat (8 * div) @(posedge clk);
    do_req(1'b0, base + 56'hBFF8, 2'd3, 64'd0, 1'b0, rd, er, rv, sw, k);
    exp = model_mtime(k - 1);
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL idle_mtime: got %h expected %h", rd, exp); end
    n_checks++; if (rd < 64'd7 || rd > 64'd9) begin n_fail++; $display("FAIL idle_mtime_range: got %h expected 8+-1", rd); end
    n_checks++; if (rv !== 1'b1 || er !== 1'b0) begin n_fail++; $display("FAIL idle_resp: got v=%b err=%b expected v=1 err=0", rv, er); end
  endtask

  task automatic test_msip;
    logic [63:0] rd; logic er, rv, sw; int k;
    do_req(1'b1, base, 2'd2, 64'hFFFF_FFFF, 1'b0, rd, er, rv, sw, k);
    msip_m = 1'b1;
    n_checks++; if (sw !== 1'b1) begin n_fail++; $display("FAIL msip_set_irq: got %b expected 1", sw); end
    n_checks++; if (rd !== 64'd0 || er !== 1'b0) begin n_fail++; $display("FAIL msip_wr_resp: got data=%h err=%b expected 0/0", rd, er); end
    do_req(1'b0, base, 2'd2, 64'd0, 1'b0, rd, er, rv, sw, k);
    n_checks++; if (rd !== 64'd1) begin n_fail++; $display("FAIL msip_read: got %h expected 1", rd); end
    do_req(1'b1, base, 2'd2, 64'd0, 1'b0, rd, er, rv, sw, k);
    msip_m = 1'b0;
    n_checks++; if (sw !== 1'b0) begin n_fail++; $display("FAIL msip_clr_irq: got %b expected 0", sw); end
  endtask

  task automatic test_timer_cmp;
    logic [63:0] rd; logic er, rv, sw; int k; int guard; logic exp;
    do_req(1'b1, base + 56'h4000, 2'd3, 64'h20, 1'b0, rd, er, rv, sw, k);
    cmp_m = 64'h20;
    guard = 0;
    while (model_mtime(edge_cnt - 1) < 64'h24 && guard < 1000) begin
      exp = (model_mtime(edge_cnt - 1) >= cmp_m);
      n_checks++;
      if (timer_irq_o[0] !== exp) begin
        n_fail++;
        $display("FAIL timer_rise: got %b expected %b at mtime %h", timer_irq_o[0], exp, model_mtime(edge_cnt - 1));
      end
      @(posedge clk); #1;
      guard++;
    end
    n_checks++; if (guard >= 1000) begin n_fail++; $display("FAIL timer_wait: got timeout expected mtime 0x24"); end
    do_req(1'b1, base + 56'h4000, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, er, rv, sw, k);
    cmp_m = '1;
    n_checks++; if (timer_irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL timer_fall: got %b expected 0", timer_irq_o[0]); end
  endtask

  task automatic test_mtime_collision;
    logic [63:0] rd, pre, exp; logic er, rv, sw; int k;
    do_req(1'b1, base + 56'hBFFC, 2'd2, 64'h1, 1'b1, rd, er, rv, sw, k);
    pre = model_mtime(k - 1);
    mt_base = {32'h1, pre[31:0]};
    kw = k;
    do_req(1'b0, base + 56'hBFF8, 2'd3, 64'd0, 1'b0, rd, er, rv, sw, k);
    exp = model_mtime(k - 1);
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL collide_read: got %h expected %h", rd, exp); end
    repeat (3 * div) @(posedge clk);
    do_req(1'b0, base + 56'hBFF8, 2'd3, 64'd0, 1'b0, rd, er, rv, sw, k);
    exp = model_mtime(k - 1);
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL collide_after: got %h expected %h", rd, exp); end
  endtask

  task automatic test_random;
    logic [63:0] rd, d, exp, v; logic er, rv, sw; int k; int op; logic w; logic [1:0] sz; logic [pa-1:0] a; logic h;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 6);
      d  = {$urandom, $urandom};
      h  = 1'($urandom_range(0, 1));
      w  = 1'b0; sz = 2'd2; a = base;
      case (op)
        0: begin w = 1'b1; a = base; end
        1: begin a = base; end
        2: begin w = 1'b1; sz = 2'd3; a = base + 56'h4000; end
        3: begin w = 1'b1; a = base + 56'h4000 + (h ? 56'h4 : 56'h0); end
        4: begin sz = h ? 2'd3 : 2'd2; a = base + 56'h4000 + ((!h && $urandom_range(0, 1) == 1) ? 56'h4 : 56'h0); end
        5: begin sz = h ? 2'd3 : 2'd2; a = base + 56'hBFF8 + ((!h && $urandom_range(0, 1) == 1) ? 56'h4 : 56'h0); end
        default: begin
          w = 1'b1; sz = 2'd3; a = base + 56'hBFF8;
          if (h) d = 64'hFFFF_FFFF_FFFF_FFFE;
        end
      endcase
      do_req(w, a, sz, d, 1'b0, rd, er, rv, sw, k);
      exp = 64'd0;
      if (w) begin
        if (op == 0) msip_m = d[0];
        else if (op == 2) cmp_m = d;
        else if (op == 3) begin
          if (h) cmp_m[63:32] = d[31:0]; else cmp_m[31:0] = d[31:0];
        end else begin
          mt_base = d; kw = k;
        end
      end else begin
        if (op == 1) v = {63'b0, msip_m};
        else if (op == 4) v = cmp_m;
        else v = model_mtime(k - 1);
        if (op == 1 || sz == 2'd3) exp = v;
        else if (a[2]) exp = {32'b0, v[63:32]};
        else exp = {32'b0, v[31:0]};
      end
      n_checks++; if (rd !== exp || er !== 1'b0 || rv !== 1'b1) begin
        n_fail++; $display("FAIL rand_op%0d: got data=%h err=%b v=%b expected data=%h err=0 v=1", op, rd, er, rv, exp);
      end
      n_checks++; if (software_irq_o[0] !== msip_m) begin n_fail++; $display("FAIL rand_sw_irq: got %b expected %b", software_irq_o[0], msip_m); end
      n_checks++; if (timer_irq_o[0] !== (model_mtime(k) >= cmp_m)) begin
        n_fail++; $display("FAIL rand_tmr_irq: got %b expected %b", timer_irq_o[0], (model_mtime(k) >= cmp_m));
      end
    end
  endtask

  task automatic test_errors;
    logic [63:0] rd, exp; logic er, rv, sw; int k;
    logic [pa-1:0] ea [9] = '{base + 56'h5000, base + 56'h4004, base, base, base + 56'h4,
                              base + 56'hBFF8, base + 56'h4002, 56'h1_0200_0000, 56'h0300_4000};
    logic [1:0]    es [9] = '{2'd3, 2'd3, 2'd1, 2'd3, 2'd2, 2'd0, 2'd2, 2'd3, 2'd3};
    logic          ew [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_req(1'b1, base, 2'd2, 64'd0, 1'b0, rd, er, rv, sw, k);
    msip_m = 1'b0;
    do_req(1'b1, base + 56'h4000, 2'd3, 64'h1234_5678_9ABC_DEF0, 1'b0, rd, er, rv, sw, k);
    cmp_m = 64'h1234_5678_9ABC_DEF0;
    for (int i = 0; i < 9; i++) begin
      do_req(ew[i], ea[i], es[i], 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, rd, er, rv, sw, k);
      n_checks++; if (er !== 1'b1 || rd !== 64'd0 || rv !== 1'b1) begin
        n_fail++; $display("FAIL err_case%0d: got err=%b data=%h v=%b expected err=1 data=0 v=1", i, er, rd, rv);
      end
    end
    do_req(1'b0, base, 2'd2, 64'd0, 1'b0, rd, er, rv, sw, k);
    n_checks++; if (rd !== {63'b0, msip_m}) begin n_fail++; $display("FAIL err_msip_kept: got %h expected %h", rd, {63'b0, msip_m}); end
    do_req(1'b0, base + 56'h4000, 2'd3, 64'd0, 1'b0, rd, er, rv, sw, k);
    n_checks++; if (rd !== cmp_m) begin n_fail++; $display("FAIL err_cmp_kept: got %h expected %h", rd, cmp_m); end
    do_req(1'b0, base + 56'hBFF8, 2'd3, 64'd0, 1'b0, rd, er, rv, sw, k);
    exp = model_mtime(k - 1);
    n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL err_mtime_kept: got %h expected %h", rd, exp); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp;
    @(negedge clk);
    cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = base + 56'h4000; cmd_size = 2'd2; cmd_data = '0;
    exp = {32'b0, cmp_m[31:0]};
    @(posedge clk); #1;
    cmd_w = 1'b1; cmd_addr = base; cmd_data = 64'd1;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_v_o !== 1'b1 || cmd_ready_o !== 1'b0 || resp_data_o !== exp || resp_err_o !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: got v=%b rdy=%b data=%h err=%b expected 1/0/%h/0", i, resp_v_o, cmd_ready_o, resp_data_o, resp_err_o, exp);
      end
      n_checks++; if (software_irq_o[0] !== 1'b0) begin n_fail++; $display("FAIL hold_no_accept%0d: got %b expected 0", i, software_irq_o[0]); end
      @(posedge clk); #1;
    end
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
    n_checks++; if (cmd_ready_o !== 1'b1 || resp_v_o !== 1'b0) begin n_fail++; $display("FAIL yumi_ready: got rdy=%b v=%b expected 1/0", cmd_ready_o, resp_v_o); end
    @(posedge clk); #1;
    cmd_v = 1'b0;
    msip_m = 1'b1;
    n_checks++; if (resp_v_o !== 1'b1 || resp_data_o !== 64'd0 || resp_err_o !== 1'b0 || software_irq_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL second_cmd: got v=%b data=%h err=%b sw=%b expected 1/0/0/1", resp_v_o, resp_data_o, resp_err_o, software_irq_o[0]);
    end
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL single_accept%0d: got v=%b rdy=%b expected 0/1", i, resp_v_o, cmd_ready_o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_in_resp;
    @(negedge clk);
    cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = base + 56'hBFF8; cmd_size = 2'd3;
    @(posedge clk); #1;
    cmd_v = 1'b0;
    n_checks++; if (resp_v_o !== 1'b1) begin n_fail++; $display("FAIL rst_resp_pending: got %b expected 1", resp_v_o); end
    @(negedge clk);
    reset_i = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b1 || resp_data_o !== 64'd0 || resp_err_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_resp: got v=%b rdy=%b data=%h err=%b expected 0/1/0/0", resp_v_o, cmd_ready_o, resp_data_o, resp_err_o);
    end
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mtime_idle();
    test_msip();
    test_timer_cmp();
    test_mtime_collision();
    test_random();
    test_errors();
    test_back_to_back();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
